game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Game-control stage downstream of the bar environment.
- Consumes the eight bar positions and openings, plus the bird position from the player block.
- Performs serial collision checking once per frame tick, counts cleared bars, and advances the level.
- Drives `level` and `pause` back into the environment and raises collision/level-up events for the display and sound blocks.

Parameters:
- BAR_X0, 64, x pixel of left edge of bar index 0
- BAR_PITCH, 64, x spacing between bar left edges (bar k left = BAR_X0 + k*BAR_PITCH)
- BAR_W, 20, bar width in pixels
- BIRD_W, 16, bird sprite width
- BIRD_H, 16, bird sprite height
- LEVEL_END_X, 600, bird_x at or beyond which the level is complete

Ports:
- clk  input  1  game clock; all logic on posedge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse from debounced button; starts or restarts play
- frame_tick  input  1  one-cycle pulse, once per environment update
- bird_x  input  10  bird left edge, pixels
- bird_y  input  10  bird top edge, pixels
- bar_pos1..bar_pos8  input  10 each  top of opening, bars 0..7
- bar_op1..bar_op8  input  10 each  opening height, bars 0..7
- level  output  10  current level, feeds environment
- pause  output  1  1 = environment frozen
- collision  output  1  one-cycle pulse on hit
- level_up  output  1  one-cycle pulse on level completion
- score  output  16  bars cleared since start
- busy  output  1  high while SCAN or CHECK

Behaviour:
- Reset (rst_n low at posedge, any state, including mid-scan):
  - level=1, pause=1, collision=0, level_up=0, score=0, busy=0.
  - cleared mask=0, hit flag=0, state READY.
- States: READY, WAIT_TICK, SCAN, CHECK, DEAD. All outputs are registered.
- READY:
  - pause=1.
  - start -> WAIT_TICK with pause=0.
- WAIT_TICK:
  - On frame_tick, snapshot bird_x, bird_y and all 16 bar inputs into internal registers; clear hit; idx=0; -> SCAN.
  - Later input changes do not affect the current scan.
- SCAN: one bar per cycle, idx 0..7. All arithmetic is 11-bit unsigned so no sum wraps.
  - Terms: L = BAR_X0 + idx*BAR_PITCH; R = L + BAR_W; P = pos[idx]; O = op[idx].
  - A bar with O==0 is absent: no hit and no clear.
  - x-overlap: (bird_x + BIRD_W > L) and (bird_x < R).
  - Outside gap: (bird_y < P) or (bird_y + BIRD_H > P + O).
  - Overlap and outside -> hit=1 (sticky for this scan).
  - If bird_x >= R and mask[idx]==0: set mask[idx]; score += 1, saturating at 65535.
  - After idx 7 -> CHECK.
- CHECK:
  - If hit: collision=1 for one cycle, pause=1 -> DEAD.
  - Else if bird_x >= LEVEL_END_X:
    - level += 1, saturating at 1023.
    - level_up=1 for one cycle.
    - mask=0.
    - -> WAIT_TICK.
  - Else -> WAIT_TICK.
  - Hit has priority over level completion.
- DEAD:
  - pause=1.
  - start -> level=1, score=0, mask=0, pause=0, -> WAIT_TICK.
- Latency: frame_tick sampled at edge N -> SCAN evaluates idx 0..7 at edges N+1..N+8 -> CHECK at edge N+9.
  - collision / level_up / pause change are visible after edge N+9.
  - busy is high from edge N to edge N+9.
- Ignored inputs:
  - frame_tick is ignored in READY, SCAN, CHECK and DEAD (no queuing).
  - start is ignored in WAIT_TICK, SCAN and CHECK.
- Simultaneous start and frame_tick in READY: take start only; the tick is dropped.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles then 1, no start -> level=1, pause=1, score=0, no pulses for 100 cycles; frame_tick ignored.
- Safe pass through gap: start; bird_x=190, bird_y=250, bar_pos3=240, bar_op3=60 (bar 2 spans x 192..212); frame_tick -> collision stays 0, busy high exactly 9 cycles, state returns to WAIT_TICK.
- Collision: same as above but bird_y=230 -> collision pulses once 9 cycles after the tick; pause=1; subsequent ticks ignored; start -> pause=0, level=1, score=0.
- Scoring, absent bars and no double count: bar_op1..8=60 except bar_op1=0; bird_x=220, bird_y clear of all gaps -> score=2 after the first tick (bars 1 and 2; bar 0 absent); a second tick with the same inputs -> score stays 2.
- Level up and saturation: bird_x=600, no hit -> level_up pulse, level 1->2, mask cleared; force level=1023 path -> level stays 1023.
- Reset mid-scan and tick overrun: assert rst_n=0 at SCAN idx 4 -> all outputs at reset values next cycle; separately, a frame_tick during SCAN -> no second scan starts.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl -- game-control stage downstream of the bar environment.
//
// Once per frame tick the bird position and all eight bar descriptors are
// snapshotted, then the bars are checked serially (one per clock) for a
// collision with the bird and for being cleared (bird fully past the bar).
// A final CHECK cycle raises the collision or level-up event and updates
// the level / pause controls fed back into the environment.
//
// Ports:
//   clk                 game clock, all logic on posedge
//   rst_n               synchronous active-low reset
//   start               one-cycle pulse, starts or restarts play
//   frame_tick          one-cycle pulse, once per environment update
//   bird_x, bird_y      bird left / top edge in pixels (10 bit)
//   bar_pos1..bar_pos8  top of opening for bars 0..7 (10 bit)
//   bar_op1..bar_op8    opening height for bars 0..7 (10 bit), 0 = bar absent
//   level               current level, 1..1023
//   pause               1 = environment frozen
//   collision           one-cycle pulse on hit
//   level_up            one-cycle pulse on level completion
//   score               bars cleared since start, saturating at 65535
//   busy                high while scanning or checking

module game_ctrl #(
  parameter int unsigned BAR_X0      = 64,
  parameter int unsigned BAR_PITCH   = 64,
  parameter int unsigned BAR_W       = 20,
  parameter int unsigned BIRD_W      = 16,
  parameter int unsigned BIRD_H      = 16,
  parameter int unsigned LEVEL_END_X = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [9:0]  bird_x,
  input  logic [9:0]  bird_y,
  input  logic [9:0]  bar_pos1,
  input  logic [9:0]  bar_pos2,
  input  logic [9:0]  bar_pos3,
  input  logic [9:0]  bar_pos4,
  input  logic [9:0]  bar_pos5,
  input  logic [9:0]  bar_pos6,
  input  logic [9:0]  bar_pos7,
  input  logic [9:0]  bar_pos8,
  input  logic [9:0]  bar_op1,
  input  logic [9:0]  bar_op2,
  input  logic [9:0]  bar_op3,
  input  logic [9:0]  bar_op4,
  input  logic [9:0]  bar_op5,
  input  logic [9:0]  bar_op6,
  input  logic [9:0]  bar_op7,
  input  logic [9:0]  bar_op8,
  output logic [9:0]  level,
  output logic        pause,
  output logic        collision,
  output logic        level_up,
  output logic [15:0] score,
  output logic        busy
);

  typedef enum logic [2:0] {
    READY,
    WAIT_TICK,
    SCAN,
    CHECK,
    DEAD
  } state_t;

  state_t     state;

  // Frame snapshot: the scan works only on these, so input changes after
  // the tick cannot disturb a scan in progress.
  logic [9:0] bx_q;
  logic [9:0] by_q;
  logic [9:0] pos_q [8];
  logic [9:0] op_q  [8];

  logic [2:0] idx;
  logic [7:0] mask;
  logic       hit;

  // Per-bar geometry for the bar currently addressed by idx. Everything is
  // widened to 11 bits so that bird_x + BIRD_W and pos + op cannot wrap.
  logic [10:0] bar_l;
  logic [10:0] bar_r;
  logic [10:0] bx_w;
  logic [10:0] by_w;
  logic [10:0] p_w;
  logic [10:0] o_w;
  logic        present;
  logic        overlap;
  logic        outside;
  logic        hit_now;
  logic        clear_now;
  logic        level_done;

  always_comb begin
    bar_l      = 11'(BAR_X0 + 32'(idx) * BAR_PITCH);
    bar_r      = bar_l + 11'(BAR_W);
    bx_w       = {1'b0, bx_q};
    by_w       = {1'b0, by_q};
    p_w        = {1'b0, pos_q[idx]};
    o_w        = {1'b0, op_q[idx]};
    present    = (o_w != '0);
    overlap    = (bx_w + 11'(BIRD_W) > bar_l) && (bx_w < bar_r);
    outside    = (by_w < p_w) || (by_w + 11'(BIRD_H) > p_w + o_w);
    hit_now    = present && overlap && outside;
    clear_now  = present && (bx_w >= bar_r) && !mask[idx];
    level_done = (bx_w >= 11'(LEVEL_END_X));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= READY;
      level     <= 10'd1;
      pause     <= 1'b1;
      collision <= 1'b0;
      level_up  <= 1'b0;
      score     <= '0;
      busy      <= 1'b0;
      mask      <= '0;
      hit       <= 1'b0;
      idx       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
    end else begin
      // Event outputs are single-cycle pulses unless re-asserted below.
      collision <= 1'b0;
      level_up  <= 1'b0;

      case (state)
        READY: begin
          pause <= 1'b1;
          // A tick arriving together with start is simply dropped.
          if (start) begin
            pause <= 1'b0;
            state <= WAIT_TICK;
          end
        end

        WAIT_TICK: begin
          if (frame_tick) begin
            bx_q     <= bird_x;
            by_q     <= bird_y;
            pos_q[0] <= bar_pos1;
            pos_q[1] <= bar_pos2;
            pos_q[2] <= bar_pos3;
            pos_q[3] <= bar_pos4;
            pos_q[4] <= bar_pos5;
            pos_q[5] <= bar_pos6;
            pos_q[6] <= bar_pos7;
            pos_q[7] <= bar_pos8;
            op_q[0]  <= bar_op1;
            op_q[1]  <= bar_op2;
            op_q[2]  <= bar_op3;
            op_q[3]  <= bar_op4;
            op_q[4]  <= bar_op5;
            op_q[5]  <= bar_op6;
            op_q[6]  <= bar_op7;
            op_q[7]  <= bar_op8;
            hit      <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (hit_now) begin
            hit <= 1'b1;
          end
          if (clear_now) begin
            mask[idx] <= 1'b1;
            if (score != 16'hFFFF) begin
              score <= score + 16'd1;
            end
          end
          if (idx == 3'd7) begin
            state <= CHECK;
          end else begin
            idx <= idx + 3'd1;
          end
        end

        CHECK: begin
          busy <= 1'b0;
          if (hit) begin
            collision <= 1'b1;
            pause     <= 1'b1;
            state     <= DEAD;
          end else if (level_done) begin
            if (level != 10'h3FF) begin
              level <= level + 10'd1;
            end
            level_up <= 1'b1;
            mask     <= '0;
            state    <= WAIT_TICK;
          end else begin
            state <= WAIT_TICK;
          end
        end

        DEAD: begin
          pause <= 1'b1;
          if (start) begin
            level <= 10'd1;
            score <= '0;
            mask  <= '0;
            pause <= 1'b0;
            state <= WAIT_TICK;
          end
        end

        default: begin
          state <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl -- directed and randomized bench for game_ctrl with an
// arithmetic reference model of the per-frame collision/clear rules.

module tb_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        frame_tick;
  logic [9:0]  bird_x;
  logic [9:0]  bird_y;
  logic [9:0]  bpos [8];
  logic [9:0]  bop  [8];
  logic [9:0]  level;
  logic        pause;
  logic        collision;
  logic        level_up;
  logic [15:0] score;
  logic        busy;

  game_ctrl #(
    .BAR_X0      (64),
    .BAR_PITCH   (64),
    .BAR_W       (20),
    .BIRD_W      (16),
    .BIRD_H      (16),
    .LEVEL_END_X (600)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_tick (frame_tick),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .bar_pos1   (bpos[0]),
    .bar_pos2   (bpos[1]),
    .bar_pos3   (bpos[2]),
    .bar_pos4   (bpos[3]),
    .bar_pos5   (bpos[4]),
    .bar_pos6   (bpos[5]),
    .bar_pos7   (bpos[6]),
    .bar_pos8   (bpos[7]),
    .bar_op1    (bop[0]),
    .bar_op2    (bop[1]),
    .bar_op3    (bop[2]),
    .bar_op4    (bop[3]),
    .bar_op5    (bop[4]),
    .bar_op6    (bop[5]),
    .bar_op7    (bop[6]),
    .bar_op8    (bop[7]),
    .level      (level),
    .pause      (pause),
    .collision  (collision),
    .level_up   (level_up),
    .score      (score),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: game-level view (playing / dead / ready) plus counters.
  int m_level;
  int m_score;
  bit m_cleared [8];
  bit m_pause;
  bit m_playing;
  bit m_dead;
  bit m_hit;
  bit m_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_level   = 1;
    m_score   = 0;
    m_pause   = 1'b1;
    m_playing = 1'b0;
    m_dead    = 1'b0;
    foreach (m_cleared[k]) m_cleared[k] = 1'b0;
  endtask

  // Apply the frame rules to one snapshot of inputs.
  task automatic model_frame(input int bx, input int by, input int p [8], input int o [8]);
    int l, r;
    m_hit = 1'b0;
    m_lvl = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (o[k] == 0) continue;
      l = 64 + 64 * k;
      r = l + 20;
      if ((bx + 16 > l) && (bx < r) && ((by < p[k]) || (by + 16 > p[k] + o[k])))
        m_hit = 1'b1;
      if (bx >= r && !m_cleared[k]) begin
        m_cleared[k] = 1'b1;
        if (m_score < 65535) m_score++;
      end
    end
    if (m_hit) begin
      m_pause   = 1'b1;
      m_dead    = 1'b1;
      m_playing = 1'b0;
    end else if (bx >= 600) begin
      m_lvl = 1'b1;
      if (m_level < 1023) m_level++;
      foreach (m_cleared[k]) m_cleared[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(m_level));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".pause"}, 32'(pause), 32'(m_pause));
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    if (m_dead) begin
      m_level = 1;
      m_score = 0;
      foreach (m_cleared[k]) m_cleared[k] = 1'b0;
    end
    if (m_dead || !m_playing) begin
      m_dead    = 1'b0;
      m_playing = 1'b1;
      m_pause   = 1'b0;
    end
    check_outputs("start");
    chk("start.busy", 32'(busy), 32'd0);
  endtask

  // One full frame: tick, 8 scan cycles, check cycle, one trailing cycle.
  // extra: pulse frame_tick mid-scan; scramble: change inputs after snapshot.
  task automatic do_frame(input string tag, input bit extra, input bit scramble);
    int p [8];
    int o [8];
    int bx, by;
    bx = int'(bird_x);
    by = int'(bird_y);
    for (int k = 0; k < 8; k++) begin
      p[k] = int'(bpos[k]);
      o[k] = int'(bop[k]);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk({tag, ".busy_first"}, 32'(busy), 32'd1);
    if (scramble) begin
      bird_x = 10'($urandom_range(0, 700));
      bird_y = 10'($urandom_range(0, 500));
      for (int k = 0; k < 8; k++) begin
        bpos[k] = 10'($urandom_range(0, 500));
        bop[k]  = 10'($urandom_range(0, 200));
      end
    end
    model_frame(bx, by, p, o);
    for (int i = 1; i <= 8; i++) begin
      if (extra && i == 3) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk({tag, ".busy_scan"}, 32'(busy), 32'd1);
      chk({tag, ".no_pulse_scan"}, 32'({collision, level_up}), 32'd0);
    end
    step();
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".collision"}, 32'(collision), 32'(m_hit));
    chk({tag, ".level_up"}, 32'(level_up), 32'(m_lvl));
    check_outputs(tag);
    step();
    chk({tag, ".pulse_end"}, 32'({collision, level_up}), 32'd0);
    chk({tag, ".no_rescan"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_bars();
    for (int k = 0; k < 8; k++) begin
      bpos[k] = '0;
      bop[k]  = '0;
    end
  endtask

  initial begin
    int watch;
    rst_n      = 1'b0;
    start      = 1'b0;
    frame_tick = 1'b0;
    bird_x     = '0;
    bird_y     = '0;
    clear_bars();
    model_reset();

    // Reset, then idle with an ignored tick.
    step();
    step();
    rst_n = 1'b1;
    step();
    check_outputs("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.pulses", 32'({collision, level_up}), 32'd0);
    watch = 0;
    for (int i = 0; i < 100; i++) begin
      frame_tick = (i == 50);
      step();
      watch = watch | int'({busy, collision, level_up, ~pause});
    end
    frame_tick = 1'b0;
    chk("idle.quiet", 32'(watch), 32'd0);
    check_outputs("idle");

    // Start together with a tick: tick is dropped.
    start      = 1'b1;
    frame_tick = 1'b1;
    step();
    start      = 1'b0;
    frame_tick = 1'b0;
    m_playing  = 1'b1;
    m_pause    = 1'b0;
    chk("start_tick.busy", 32'(busy), 32'd0);
    check_outputs("start_tick");
    step();
    chk("start_tick.busy2", 32'(busy), 32'd0);

    // Safe pass through bar 2's gap.
    bird_x  = 10'd190;
    bird_y  = 10'd250;
    bpos[2] = 10'd240;
    bop[2]  = 10'd60;
    do_frame("safe", 1'b0, 1'b0);

    // Start ignored in WAIT_TICK.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wait_start.pause", 32'(pause), 32'd0);

    // Collision, tick overrun during scan, then ignored ticks while dead.
    bird_y = 10'd230;
    do_frame("hit", 1'b1, 1'b0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("dead.tick_ignored", 32'(busy), 32'd0);
    chk("dead.pause", 32'(pause), 32'd1);
    press_start();

    // Scoring, absent bar 0, no double count.
    for (int k = 0; k < 8; k++) begin
      bpos[k] = 10'd80;
      bop[k]  = 10'd60;
    end
    bop[0] = '0;
    bird_x = 10'd220;
    bird_y = 10'd100;
    do_frame("score1", 1'b0, 1'b0);
    chk("score1.value", 32'(score), 32'd2);
    do_frame("score2", 1'b0, 1'b0);
    chk("score2.value", 32'(score), 32'd2);

    // Level completion clears the mask: all bars re-scored each level.
    bird_x = 10'd600;
    do_frame("lvl1", 1'b0, 1'b0);
    chk("lvl1.level", 32'(level), 32'd2);
    do_frame("lvl2", 1'b0, 1'b0);

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      if (m_dead) press_start();
      bird_x = 10'($urandom_range(0, 700));
      bird_y = 10'($urandom_range(0, 500));
      for (int k = 0; k < 8; k++) begin
        bpos[k] = 10'($urandom_range(0, 500));
        bop[k]  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(40, 300));
      end
      do_frame("rand", 1'($urandom_range(0, 1)), 1'b1);
    end
    if (m_dead) press_start();

    // Reset while bar 4 is being scanned.
    bird_x = 10'd600;
    clear_bars();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    check_outputs("midscan_rst");
    chk("midscan_rst.busy", 32'(busy), 32'd0);
    chk("midscan_rst.pulses", 32'({collision, level_up}), 32'd0);
    step();
    chk("midscan_rst.ready", 32'({busy, pause}), 32'd1);

    // Level saturation at 1023.
    press_start();
    for (int i = 0; i < 1023; i++) do_frame("sat", 1'b0, 1'b0);
    chk("sat.level", 32'(level), 32'd1023);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
